// File: rtl/one_hot_encoder_pipe.sv
// One-hot to binary index encoder, two registered stages with valid/ready
// on both sides. Illegal codes (no bit or several bits set) are flagged on
// the result and counted, saturating, as they are delivered downstream.
module one_hot_encoder_pipe #(
    parameter int WIDTH_OUTPUT    = 2,
    parameter int WIDTH_INPUT     = 2**WIDTH_OUTPUT,
    parameter int ERR_COUNT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH_INPUT-1:0]     array_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH_OUTPUT-1:0]    array_out,
    output logic                       out_error,
    output logic [ERR_COUNT_WIDTH-1:0] error_count
);

    // vld_pipe_q[1] = S1 occupied, vld_pipe_q[2] = S2 occupied (out_valid)
    logic [2:1]                 vld_pipe_d, vld_pipe_q;
    logic [WIDTH_INPUT-1:0]     s1_data_d, s1_data_q;
    logic                       s1_zero_d, s1_zero_q;
    logic                       s1_multi_d, s1_multi_q;
    logic [WIDTH_OUTPUT-1:0]    idx_d, idx_q;
    logic                       err_d, err_q;
    logic [ERR_COUNT_WIDTH-1:0] cnt_d, cnt_q;
    logic                       adv1, adv2;
    logic [WIDTH_OUTPUT-1:0]    low_idx;

    // Stage advance: S2 moves when empty or drained; S1 moves when empty or S2 moves
    always_comb begin
        adv2 = !vld_pipe_q[2] || out_ready;
        adv1 = !vld_pipe_q[1] || adv2;
    end

    // Lowest set bit of the S1 vector; scanning downward lets the lowest win
    always_comb begin
        low_idx = '0;
        for (int i = WIDTH_INPUT - 1; i >= 0; i--) begin
            if (s1_data_q[i]) low_idx = WIDTH_OUTPUT'(i);
        end
    end

    // Next-state for both stages and the saturating error counter
    always_comb begin
        vld_pipe_d = vld_pipe_q;
        s1_data_d  = s1_data_q;
        s1_zero_d  = s1_zero_q;
        s1_multi_d = s1_multi_q;
        idx_d      = idx_q;
        err_d      = err_q;
        cnt_d      = cnt_q;

        // S1 only samples array_in on an actual accept
        if (adv1) begin
            vld_pipe_d[1] = in_valid;
            if (in_valid) begin
                s1_data_d  = array_in;
                s1_zero_d  = (array_in == '0);
                // clearing the lowest set bit leaves something iff >1 bit set
                s1_multi_d = ((array_in & (array_in - WIDTH_INPUT'(1))) != '0);
            end
        end

        // S2 holds its result while stalled
        if (adv2) begin
            vld_pipe_d[2] = vld_pipe_q[1];
            if (vld_pipe_q[1]) begin
                idx_d = low_idx;
                err_d = s1_zero_q | s1_multi_q;
            end
        end

        // Count errored results as they leave, stick at all-ones
        if (vld_pipe_q[2] && out_ready && err_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + ERR_COUNT_WIDTH'(1);
        end
    end

    // Pipeline registers; reset drops anything in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe_q <= '0;
            s1_data_q  <= '0;
            s1_zero_q  <= 1'b0;
            s1_multi_q <= 1'b0;
            idx_q      <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            s1_data_q  <= s1_data_d;
            s1_zero_q  <= s1_zero_d;
            s1_multi_q <= s1_multi_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready    = adv1;
    assign out_valid   = vld_pipe_q[2];
    assign array_out   = idx_q;
    assign out_error   = err_q;
    assign error_count = cnt_q;

endmodule
